// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the asynchronous FIFO. The storage array,
// the pointer logic and the bench all size themselves from this package, so
// they always agree on the word width and depth.
//   WORD    : data word width in bits
//   LEN_POW : address width in bits
//   LEN     : number of entries (always a power of two)
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int WORD    = 8;
  localparam int LEN_POW = 3;
  localparam int LEN     = 1 << LEN_POW;

  typedef logic [WORD-1:0]    word_t;
  typedef logic [LEN_POW-1:0] addr_t;

  // Next address with natural wrap. The depth is a power of two, so the
  // pointer logic can simply let the counter overflow (LEN-1 -> 0).
  function automatic addr_t addr_inc(input addr_t a);
    return addr_t'(a + 1'b1);
  endfunction

endpackage

// File: rtl/mem_if.sv
// ---------------------------------------------------------------------------
// mem_if
// Bundles the write and read ports of the FIFO storage array.
//   ena    : write enable, sampled on the clock rising edge
//   w_addr : write address
//   w_word : write data
//   r_addr : read address
//   r_word : read data (combinational from r_addr)
// master : the pointer logic (drives addresses/data, reads r_word)
// slave  : the storage array
// ---------------------------------------------------------------------------
interface mem_if;
  import mem_pkg::*;

  logic  ena;
  addr_t w_addr;
  word_t w_word;
  addr_t r_addr;
  word_t r_word;

  modport master (
    output ena,
    output w_addr,
    output w_word,
    output r_addr,
    input  r_word
  );

  modport slave (
    input  ena,
    input  w_addr,
    input  w_word,
    input  r_addr,
    output r_word
  );

endinterface

// File: rtl/mem.sv
// ---------------------------------------------------------------------------
// mem
// Dual-port storage array for the asynchronous FIFO: LEN words of WORD bits,
// one synchronous write port and one combinational read port.
// It holds no full/empty knowledge; the pointer logic prevents overruns.
//   clk : clock, rising edge active
//   rst : asynchronous, active-low reset; clears every entry immediately
//   bus : mem_if slave port (ena, w_addr, w_word, r_addr, r_word)
// ---------------------------------------------------------------------------
module mem
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mem_if.slave bus
);

  // Name kept as-is: benches reach into it hierarchically.
  word_t memArray [0:LEN-1];

  // Reset clears the whole array without waiting for a clock, which is why
  // this stays a register array rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LEN; i++) begin
        memArray[i] <= '0;
      end
    end else if (bus.ena) begin
      memArray[bus.w_addr] <= bus.w_word;
    end
  end

  // No forwarding: on a same-address write the old word is visible until the
  // edge and the new one right after it.
  assign bus.r_word = memArray[bus.r_addr];

endmodule

// File: tb/tb_mem.sv
// ---------------------------------------------------------------------------
// tb_mem
// Self-checking bench for mem: directed test-plan steps followed by random
// traffic, all checked against an array model of the storage.
// ---------------------------------------------------------------------------
module tb_mem;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  word_t model [LEN];

  mem_if bus ();

  mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare r_word against an expected value.
  task automatic check(input string tag, input word_t exp);
    vectors++;
    assert (bus.r_word === exp) else begin
      miscompares++;
      $error("FAIL %s: r_word=%h expected %h", tag, bus.r_word, exp);
    end
  endtask

  // Compare an array entry read hierarchically.
  task automatic check_cell(input string tag, input int idx, input word_t exp);
    vectors++;
    assert (dut.memArray[idx] === exp) else begin
      miscompares++;
      $error("FAIL %s: memArray[%0d]=%h expected %h", tag, idx, dut.memArray[idx], exp);
    end
  endtask

  // Set read address, let the combinational path settle, compare with model.
  task automatic read_check(input string tag, input addr_t a);
    bus.r_addr = a;
    #1;
    check(tag, model[a]);
  endtask

  // One clock of write traffic; inputs change on the falling edge.
  task automatic do_write(input addr_t a, input word_t d, input logic en);
    @(negedge clk);
    bus.ena    = en;
    bus.w_addr = a;
    bus.w_word = d;
    @(posedge clk);
    #1;
    if (en && rst) model[a] = d;
    bus.ena = 1'b0;
  endtask

  // Assert reset away from any edge and confirm every address reads zero.
  task automatic pulse_reset_check(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < LEN; i++) model[i] = '0;
    #0;
    for (int i = 0; i < LEN; i++) begin
      bus.r_addr = addr_t'(i);
      #0.5;
      check(tag, word_t'(0));
    end
  endtask

  initial begin
    addr_t ra;
    addr_t wa;
    word_t wd;
    logic  we;

    vectors     = 0;
    miscompares = 0;
    bus.ena     = 1'b0;
    bus.w_addr  = '0;
    bus.w_word  = '0;
    bus.r_addr  = '0;
    rst         = 1'b0;
    for (int i = 0; i < LEN; i++) model[i] = '0;

    // Reset state.
    #3;
    for (int i = 0; i < LEN; i++) read_check("reset_state", addr_t'(i));

    // Writes are ignored while reset is held.
    do_write(3'd2, 8'h77, 1'b1);
    read_check("write_in_reset", 3'd2);
    @(negedge clk);
    rst = 1'b1;

    // 1. Fill with 0xFF, then reset clears everything with no clock edge.
    for (int i = 0; i < LEN; i++) do_write(addr_t'(i), 8'hFF, 1'b1);
    read_check("fill_ff", 3'd6);
    pulse_reset_check("reset_clears");
    @(negedge clk);
    rst = 1'b1;

    // 2. Sequential fill i -> i.
    for (int i = 0; i < LEN; i++) do_write(addr_t'(i), word_t'(i), 1'b1);
    for (int i = 0; i < LEN; i++) check_cell("seq_fill", i, word_t'(i));

    // 3. Readback 0..7.
    for (int i = 0; i < LEN; i++) begin
      bus.r_addr = addr_t'(i);
      #1;
      check("readback", word_t'(i));
    end

    // 4. Write gating.
    for (int k = 0; k < 4; k++) do_write(3'd3, 8'hAA, 1'b0);
    check_cell("write_gate", 3, 8'h03);
    read_check("write_gate_rd", 3'd3);

    // 5. Collision on address 5.
    @(negedge clk);
    bus.r_addr = 3'd5;
    bus.w_addr = 3'd5;
    bus.w_word = 8'h5A;
    bus.ena    = 1'b1;
    #1;
    check("collision_before", 8'h05);
    @(posedge clk);
    #1;
    model[5] = 8'h5A;
    check("collision_after", 8'h5A);
    bus.ena = 1'b0;

    // 6. Wrap-around writes 7 then 0.
    do_write(3'd7, 8'hC7, 1'b1);
    do_write(addr_inc(3'd7), 8'hC0, 1'b1);
    read_check("wrap_7", 3'd7);
    read_check("wrap_0", 3'd0);
    check_cell("wrap_cell0", 0, 8'hC0);

    // Mid-stream reset between two writes, then recovery.
    pulse_reset_check("midstream_reset");
    @(negedge clk);
    rst = 1'b1;
    do_write(3'd4, 8'h3C, 1'b1);
    read_check("post_reset_write", 3'd4);
    read_check("post_reset_other", 3'd7);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      ra = addr_t'($urandom_range(LEN - 1));
      wa = addr_t'($urandom_range(LEN - 1));
      wd = word_t'($urandom);
      we = ($urandom_range(3) != 0);
      @(negedge clk);
      bus.r_addr = ra;
      bus.w_addr = wa;
      bus.w_word = wd;
      bus.ena    = we;
      #1;
      check("rand_pre", model[ra]);
      @(posedge clk);
      #1;
      if (we) model[wa] = wd;
      check("rand_post", model[ra]);
    end
    bus.ena = 1'b0;

    // Final sweep of the whole array.
    for (int i = 0; i < LEN; i++) read_check("final_sweep", addr_t'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
